// File: rtl/regfile_reader_pkg.sv
// Shared widths and FSM encoding for the register-file reader.
// Imported by the reader top and its display decoder.
package regfile_reader_pkg;

  localparam int CPU_WSIZE  = 4;
  localparam int RSEL_WIDTH = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

endpackage

// File: rtl/hex_7seg.sv
// Hex nibble to active-high seven-segment pattern.
// Bit order of seg is {g,f,e,d,c,b,a}.
module hex_7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/regfile_reader.sv
// Walks a register file one word at a time and presents each word
// on a valid/ready port, with an optional dwell between words.
module regfile_reader
  import regfile_reader_pkg::*;
#(
  parameter int WIDTH = CPU_WSIZE,
  parameter int AW    = RSEL_WIDTH,
  parameter int DWELL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             single,
  input  logic [AW-1:0]    first_addr,
  input  logic             abort,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_addr,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic [6:0]       disp_addr,
  output logic [6:0]       disp_data
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DLOAD =
    DW'((DWELL > 0) ? DWELL - 1 : 0);
  localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  state_t           r_state;
  logic [AW-1:0]    r_addr;
  logic [AW:0]      r_count;
  logic [DW-1:0]    r_dwell;
  logic [AW-1:0]    r_oaddr;
  logic [WIDTH-1:0] r_odata;
  logic             r_done;

  state_t           w_state;
  logic [AW-1:0]    w_addr;
  logic [AW:0]      w_count;
  logic [DW-1:0]    w_dwell;
  logic             w_cap;
  logic             w_done;

  always_comb begin
    w_state = r_state;
    w_addr  = r_addr;
    w_count = r_count;
    w_dwell = r_dwell;
    w_cap   = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state = S_FETCH;
          w_addr  = first_addr;
          w_count = single ? ONE : FULL;
        end
      end
      S_FETCH: begin
        w_cap   = 1'b1;
        w_state = S_PRESENT;
      end
      S_PRESENT: begin
        if (out_ready) begin
          w_count = r_count - ONE;
          w_addr  = r_addr + 1'b1;
          if (DWELL > 0) begin
            w_state = S_HOLD;
            w_dwell = DLOAD;
          end else if (w_count == '0) begin
            w_state = S_IDLE;
            w_done  = 1'b1;
          end else begin
            w_state = S_FETCH;
          end
        end
      end
      S_HOLD: begin
        if (r_dwell == '0) begin
          if (r_count == '0) begin
            w_state = S_IDLE;
            w_done  = 1'b1;
          end else begin
            w_state = S_FETCH;
          end
        end else begin
          w_dwell = r_dwell - 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
    // a word handed over alongside abort still counts as delivered
    if (abort) begin
      w_state = S_IDLE;
      w_done  = 1'b0;
      w_cap   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_count <= '0;
      r_dwell <= '0;
      r_oaddr <= '0;
      r_odata <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_addr  <= w_addr;
      r_count <= w_count;
      r_dwell <= w_dwell;
      r_done  <= w_done;
      if (w_cap) begin
        r_oaddr <= r_addr;
        r_odata <= rd_data;
      end
    end
  end

  assign rd_addr   = r_addr;
  assign out_valid = (r_state == S_PRESENT);
  assign out_addr  = r_oaddr;
  assign out_data  = r_odata;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

  logic [3:0] w_anib;
  logic [3:0] w_dnib;

  assign w_anib = 4'(r_oaddr);
  assign w_dnib = 4'(r_odata);

  hex_7seg u_seg_addr (
    .hex (w_anib),
    .seg (disp_addr)
  );

  hex_7seg u_seg_data (
    .hex (w_dnib),
    .seg (disp_data)
  );

endmodule
